// File: rtl/lcd_text_sequencer.sv
`default_nettype none
// ============================================================================
// lcd_text_sequencer : walks the text buffer, reads glyph columns from the font
//                      ROM and streams command/data bytes to the LCD serialiser.
// Optional macro     : LCD_SEQ_INVERT_EN (txt_data bit7 selects inverse video)
// Revision           : 1.0 - initial release
// ============================================================================
module lcd_text_sequencer #(
   parameter int COLS         = 14,
   parameter int ROWS         = 6,
   parameter int SYMBOL_WIDTH = 5,
   parameter int GAP          = 1,
   parameter int ROM_LAT      = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic        txt_we,
   input  logic [6:0]  txt_addr,
   input  logic [7:0]  txt_data,
   output logic [14:0] font_addr,
   output logic        font_step,
   output logic        font_clear,
   input  logic [7:0]  font_data,
   output logic        lcd_valid,
   input  logic        lcd_ready,
   output logic        lcd_dc,
   output logic [7:0]  lcd_data
);

   localparam int DEPTH = COLS * ROWS;
   localparam int ROW_W = (ROWS > 1)         ? $clog2(ROWS)         : 1;
   localparam int COL_W = (COLS > 1)         ? $clog2(COLS)         : 1;
   localparam int K_W   = (SYMBOL_WIDTH > 1) ? $clog2(SYMBOL_WIDTH) : 1;
   localparam int G_W   = (GAP > 1)          ? $clog2(GAP)          : 1;
   localparam int W_W   = (ROM_LAT > 1)      ? $clog2(ROM_LAT)      : 1;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_CLEAR     = 4'd1;
   localparam logic [3:0] S_ROW_Y     = 4'd2;
   localparam logic [3:0] S_ROW_X     = 4'd3;
   localparam logic [3:0] S_CHAR_LOAD = 4'd4;
   localparam logic [3:0] S_CHAR_WAIT = 4'd5;
   localparam logic [3:0] S_COL_SEND  = 4'd6;
   localparam logic [3:0] S_COL_WAIT  = 4'd7;
   localparam logic [3:0] S_GAP_SEND  = 4'd8;
   localparam logic [3:0] S_NEXT      = 4'd9;

   logic [3:0]       state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [G_W-1:0]   g_q, g_d;
   logic [W_W-1:0]   wait_q, wait_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [14:0]      font_addr_q, font_addr_d;
   logic             inv_q, inv_d;
   logic             font_step_q, font_step_d;
   logic             font_clear_q, font_clear_d;
   logic             lcd_valid_q, lcd_valid_d;
   logic             lcd_dc_q, lcd_dc_d;
   logic [7:0]       lcd_data_q, lcd_data_d;

   // Entries hold code^0x20 so the all-zero power-up RAM reads back as spaces.
   logic [7:0] mem [DEPTH];
   logic [6:0] rd_idx;
   logic [7:0] rd_char;
   logic       xfer;

   always_ff @(posedge clock) begin
      if (txt_we && (int'(txt_addr) < DEPTH))
         mem[txt_addr] <= txt_data ^ 8'h20;
   end

   assign rd_idx  = 7'(int'(row_q) * COLS + int'(col_q));
   assign rd_char = mem[rd_idx] ^ 8'h20;
   assign xfer    = lcd_valid_q & lcd_ready;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      k_d          = k_q;
      g_d          = g_q;
      wait_d       = wait_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      font_addr_d  = font_addr_q;
      inv_d        = inv_q;
      font_step_d  = 1'b0;
      font_clear_d = 1'b0;
      lcd_valid_d  = lcd_valid_q;
      lcd_dc_d     = lcd_dc_q;
      lcd_data_d   = lcd_data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_CLEAR;
               busy_d       = 1'b1;
               font_clear_d = 1'b1;
            end
         end
         S_CLEAR: begin
            row_d       = '0;
            state_d     = S_ROW_Y;
            lcd_valid_d = 1'b1;
            lcd_dc_d    = 1'b0;
            lcd_data_d  = 8'h40;
         end
         S_ROW_Y: begin
            if (xfer) begin
               state_d    = S_ROW_X;
               lcd_data_d = 8'h80;
            end
         end
         S_ROW_X: begin
            if (xfer) begin
               col_d       = '0;
               lcd_valid_d = 1'b0;
               state_d     = S_CHAR_LOAD;
            end
         end
         S_CHAR_LOAD: begin
`ifdef LCD_SEQ_INVERT_EN
            font_addr_d = {8'h00, rd_char[6:0]};
            inv_d       = rd_char[7];
`else
            font_addr_d = {7'h00, rd_char};
            inv_d       = 1'b0;
`endif
            wait_d  = '0;
            state_d = S_CHAR_WAIT;
         end
         S_CHAR_WAIT, S_COL_WAIT: begin
            if (wait_q == W_W'(ROM_LAT - 1)) begin
               if (state_q == S_CHAR_WAIT)
                  k_d = '0;
               state_d     = S_COL_SEND;
               lcd_valid_d = 1'b1;
               lcd_dc_d    = 1'b1;
               lcd_data_d  = font_data ^ {8{inv_q}};
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_COL_SEND: begin
            if (xfer) begin
               if (k_q != K_W'(SYMBOL_WIDTH - 1)) begin
                  font_step_d = 1'b1;
                  k_d         = k_q + 1'b1;
                  wait_d      = '0;
                  lcd_valid_d = 1'b0;
                  state_d     = S_COL_WAIT;
               end else if (GAP > 0) begin
                  g_d        = '0;
                  lcd_data_d = {8{inv_q}};
                  state_d    = S_GAP_SEND;
               end else begin
                  lcd_valid_d = 1'b0;
                  state_d     = S_NEXT;
               end
            end
         end
         S_GAP_SEND: begin
            if (xfer) begin
               if (g_q == G_W'(GAP - 1)) begin
                  lcd_valid_d = 1'b0;
                  state_d     = S_NEXT;
               end else begin
                  g_d = g_q + 1'b1;
               end
            end
         end
         S_NEXT: begin
            if (col_q == COL_W'(COLS - 1)) begin
               col_d = '0;
               if (row_q == ROW_W'(ROWS - 1)) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  row_d       = row_q + 1'b1;
                  state_d     = S_ROW_Y;
                  lcd_valid_d = 1'b1;
                  lcd_dc_d    = 1'b0;
                  lcd_data_d  = 8'h40 | 8'(row_q + 1'b1);
               end
            end else begin
               col_d   = col_q + 1'b1;
               state_d = S_CHAR_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         k_q          <= '0;
         g_q          <= '0;
         wait_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         font_addr_q  <= '0;
         inv_q        <= 1'b0;
         font_step_q  <= 1'b0;
         font_clear_q <= 1'b0;
         lcd_valid_q  <= 1'b0;
         lcd_dc_q     <= 1'b0;
         lcd_data_q   <= 8'h00;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         k_q          <= k_d;
         g_q          <= g_d;
         wait_q       <= wait_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         font_addr_q  <= font_addr_d;
         inv_q        <= inv_d;
         font_step_q  <= font_step_d;
         font_clear_q <= font_clear_d;
         lcd_valid_q  <= lcd_valid_d;
         lcd_dc_q     <= lcd_dc_d;
         lcd_data_q   <= lcd_data_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign font_addr  = font_addr_q;
   assign font_step  = font_step_q;
   assign font_clear = font_clear_q;
   assign lcd_valid  = lcd_valid_q;
   assign lcd_dc     = lcd_dc_q;
   assign lcd_data   = lcd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lcd_text_sequencer : frame-level model plus stub font ROM (code + column).
// Revision              : 1.0 - initial release
// ============================================================================
module tb_lcd_text_sequencer;

   localparam int COLS = 14;
   localparam int ROWS = 6;
   localparam int SW   = 5;
   localparam int GAP  = 1;
   localparam int NCH  = COLS * ROWS;
   localparam int FRAME_LEN = ROWS * (2 + COLS * (SW + GAP));

   logic        clock = 1'b0;
   logic        reset, start, txt_we, lcd_ready;
   logic [6:0]  txt_addr;
   logic [7:0]  txt_data, font_data, lcd_data;
   logic [14:0] font_addr;
   logic        busy, done, font_step, font_clear, lcd_valid, lcd_dc;

   lcd_text_sequencer #(.COLS(COLS), .ROWS(ROWS), .SYMBOL_WIDTH(SW), .GAP(GAP), .ROM_LAT(3)) dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .txt_we(txt_we), .txt_addr(txt_addr), .txt_data(txt_data),
      .font_addr(font_addr), .font_step(font_step), .font_clear(font_clear),
      .font_data(font_data), .lcd_valid(lcd_valid), .lcd_ready(lcd_ready),
      .lcd_dc(lcd_dc), .lcd_data(lcd_data)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Stub font ROM: registers its inputs, one more stage, output = code + column.
   logic [7:0] rom_addr_r, rom_stage;
   logic [3:0] rom_ptr;
   always @(posedge clock) begin
      rom_addr_r <= font_addr[7:0];
      rom_stage  <= rom_addr_r + 8'(rom_ptr);
      if (font_clear)
         rom_ptr <= 4'd0;
      else if (font_step)
         rom_ptr <= rom_ptr + 4'd1;
      else if (lcd_valid && lcd_ready && lcd_dc && rom_ptr == 4'(SW - 1))
         rom_ptr <= 4'd0;
   end
   assign font_data = rom_stage;

   // Expected frame built straight from the text contents.
   logic [7:0] sh [NCH];
   logic [8:0] exp_b  [FRAME_LEN];
   logic [7:0] exp_fa [FRAME_LEN];
   logic       exp_col[FRAME_LEN];
   int         exp_len = 0;

   task automatic build_model();
      int n = 0;
      logic [7:0] code, fa, b;
      logic inv;
      for (int r = 0; r < ROWS; r++) begin
         exp_b[n] = {1'b0, 8'h40 + 8'(r)}; exp_fa[n] = 8'h00; exp_col[n] = 1'b0; n++;
         exp_b[n] = {1'b0, 8'h80};         exp_fa[n] = 8'h00; exp_col[n] = 1'b0; n++;
         for (int c = 0; c < COLS; c++) begin
            code = sh[r * COLS + c];
            fa = code;
            inv = 1'b0;
`ifdef LCD_SEQ_INVERT_EN
            fa = code & 8'h7F;
            inv = code[7];
`endif
            for (int k = 0; k < SW; k++) begin
               b = fa + 8'(k);
               if (inv) b = ~b;
               exp_b[n] = {1'b1, b}; exp_fa[n] = fa; exp_col[n] = 1'b1; n++;
            end
            for (int g = 0; g < GAP; g++) begin
               exp_b[n] = {1'b1, inv ? 8'hFF : 8'h00}; exp_fa[n] = fa; exp_col[n] = 1'b0; n++;
            end
         end
      end
      exp_len = n;
   endtask

   int xfer_cnt = 0, done_cnt = 0, clr_cnt = 0, step_cnt = 0, step_win = 0, ncmd = 0;
   logic [8:0]  cap [8];
   logic [14:0] cap_fa;
   logic [7:0]  row_cmd [8];
   logic pv = 1'b0, pr = 1'b0, pdc = 1'b0;
   logic [7:0] pd = 8'h00;

   always @(negedge clock) begin
      if (reset) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr) begin
            check("hold_valid", int'(lcd_valid), 1);
            check("hold_byte", int'({lcd_dc, lcd_data}), int'({pdc, pd}));
            check("stall_no_step", int'(font_step), 0);
         end
         if (font_step) begin
            step_cnt++;
            if (xfer_cnt >= 3 && xfer_cnt <= 7) step_win++;
         end
         if (font_clear) clr_cnt++;
         if (done) done_cnt++;
         if (lcd_valid && lcd_ready) begin
            if (xfer_cnt < exp_len) begin
               check("byte", int'({lcd_dc, lcd_data}), int'(exp_b[xfer_cnt]));
               if (lcd_dc) check("font_addr", int'(font_addr), int'(exp_fa[xfer_cnt]));
            end else begin
               check("overrun_idx", xfer_cnt, exp_len - 1);
            end
            if (xfer_cnt < 8) cap[xfer_cnt] = {lcd_dc, lcd_data};
            if (xfer_cnt == 2) cap_fa = font_addr;
            if (!lcd_dc && lcd_data != 8'h80 && ncmd < 8) begin
               row_cmd[ncmd] = lcd_data;
               ncmd++;
            end
            xfer_cnt++;
         end
         pv = lcd_valid; pr = lcd_ready; pd = lcd_data; pdc = lcd_dc;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      txt_we = 1'b1; txt_addr = 7'(a); txt_data = d;
      if (a < NCH) sh[a] = d;
      tick();
      txt_we = 1'b0;
   endtask

   task automatic begin_frame();
      build_model();
      xfer_cnt = 0; done_cnt = 0; clr_cnt = 0; step_cnt = 0; step_win = 0; ncmd = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
   endtask

   task automatic finish_frame();
      int n = 0;
      while (!done && n < 6000) begin
         tick();
         n++;
      end
      check("done_seen", int'(done), 1);
      check("busy_at_done", int'(busy), 0);
      tick();
      check("done_one_cycle", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
      check("frame_len", xfer_cnt, FRAME_LEN);
      check("done_count", done_cnt, 1);
      check("clear_count", clr_cnt, 1);
      check("step_count", step_cnt, NCH * (SW - 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic found;
      reset = 1'b1; start = 1'b0; txt_we = 1'b0; txt_addr = '0; txt_data = '0; lcd_ready = 1'b1;
      for (int i = 0; i < NCH; i++) sh[i] = 8'h20;
      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_font_addr", int'(font_addr), 0);
      check("rst_font_step", int'(font_step), 0);
      check("rst_font_clear", int'(font_clear), 0);
      check("rst_lcd_valid", int'(lcd_valid), 0);
      check("rst_lcd_dc", int'(lcd_dc), 0);
      check("rst_lcd_data", int'(lcd_data), 0);
      reset = 1'b0;
      repeat (2) tick();
      check("idle_busy", int'(busy), 0);

      // Frame 1: power-up spaces
      begin_frame();
      finish_frame();
      check("f1_cmd0", int'(cap[0]), 'h040);
      check("f1_cmd1", int'(cap[1]), 'h080);
      check("f1_font_addr", int'(cap_fa), 'h20);
      check("f1_ncmd", ncmd, ROWS);
      for (int r = 0; r < ROWS; r++) check("f1_row_cmd", int'(row_cmd[r]), 'h40 + r);

      // Frame 2: 'A' in the first cell
      wr(0, 8'h41);
      begin_frame();
      finish_frame();
      check("f2_col0", int'(cap[2]), 'h141);
      check("f2_col1", int'(cap[3]), 'h142);
      check("f2_col2", int'(cap[4]), 'h143);
      check("f2_col3", int'(cap[5]), 'h144);
      check("f2_col4", int'(cap[6]), 'h145);
      check("f2_gap", int'(cap[7]), 'h100);
      check("f2_char_steps", step_win, 4);
      check("f2_font_addr", int'(cap_fa), 'h41);

      // Frame 3: stall mid column, start while busy, out-of-range write
      begin_frame();
      found = 1'b0;
      n = 0;
      while (!found && n < 3000) begin
         if (lcd_valid && lcd_dc && xfer_cnt >= 20 && xfer_cnt < exp_len && exp_col[xfer_cnt])
            found = 1'b1;
         else begin
            tick();
            n++;
         end
      end
      check("stall_reached", int'(found), 1);
      lcd_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wr(84, 8'h55);
      repeat (18) tick();
      lcd_ready = 1'b1;
      finish_frame();
      repeat (5) tick();
      check("no_restart", int'(busy), 0);

      // Frame 4: reset at transfer 100
      begin_frame();
      n = 0;
      while (xfer_cnt < 100 && n < 3000) begin
         tick();
         n++;
      end
      check("reached_100", xfer_cnt, 100);
      reset = 1'b1;
      tick();
      check("midrst_busy", int'(busy), 0);
      check("midrst_valid", int'(lcd_valid), 0);
      reset = 1'b0;
      repeat (5) tick();
      check("midrst_no_done", done_cnt, 0);
      check("midrst_idle", int'(busy), 0);

      // Frame 5: full frame after reset
      begin_frame();
      finish_frame();
      check("f5_first", int'(cap[0]), 'h040);

      // Frame 6: bit7 set in the first cell
      wr(0, 8'hC1);
      begin_frame();
      finish_frame();
`ifdef LCD_SEQ_INVERT_EN
      check("f6_font_addr", int'(cap_fa), 'h41);
      check("f6_col0", int'(cap[2]), 'h1BE);
      check("f6_col4", int'(cap[6]), 'h1BA);
      check("f6_gap", int'(cap[7]), 'h1FF);
`else
      check("f6_font_addr", int'(cap_fa), 'hC1);
      check("f6_col0", int'(cap[2]), 'h1C1);
      check("f6_col4", int'(cap[6]), 'h1C5);
      check("f6_gap", int'(cap[7]), 'h100);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
